audio_fifo_player: RTL and testbench

//  Read side of the microphone audio FIFO. Pops DATA_WIDTH-bit words from the FIFO.

---
 rtl/audio_fifo_player_if.sv | 11 +
 rtl/audio_fifo_player.sv | 110 +++++++++++
 tb/tb_audio_fifo_player.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fifo_player_if.sv
// rtl/audio_fifo_player_if.sv - FIFO read port between the audio player and the mic FIFO
interface audio_fifo_player_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd;

   modport master (input fifo_empty, input fifo_data, output fifo_rd);
   modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/audio_fifo_player.sv
// rtl/audio_fifo_player.sv - pops FIFO words and plays them MSB-first on a 1-bit audio pin
// The next word is prefetched during the last bit so consecutive words play without a gap.
module audio_fifo_player #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 171
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   audio_fifo_player_if.master fifo,
   output logic                audio_out,
   output logic                audio_sd,
   output logic                busy,
   output logic                underrun
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_WIDTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] PLAY  = 2'd3;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] BIT_PRE  = BW'(DATA_WIDTH - 2);

   logic [1:0]            state;
   logic [DW-1:0]         div_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] sreg;
   logic [DATA_WIDTH-1:0] nxt;
   logic                  nxt_valid;
   logic                  nxt_pend;
   logic                  tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         sreg         <= '0;
         nxt          <= '0;
         nxt_valid    <= 1'b0;
         nxt_pend     <= 1'b0;
         fifo.fifo_rd <= 1'b0;
         audio_out    <= 1'b0;
         audio_sd     <= 1'b0;
         busy         <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         fifo.fifo_rd <= 1'b0;
         underrun     <= 1'b0;
         nxt_pend     <= 1'b0;
         case (state)
            IDLE: begin
               audio_out <= 1'b0;
               if (enable && !fifo.fifo_empty) begin
                  fifo.fifo_rd <= 1'b1;
                  state        <= FETCH;
                  busy         <= 1'b1;
                  audio_sd     <= 1'b1;
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               sreg      <= fifo.fifo_data;
               audio_out <= fifo.fifo_data[DATA_WIDTH-1];
               bit_cnt   <= '0;
               div_cnt   <= '0;
               state     <= PLAY;
            end
            PLAY: begin
               // prefetch data lands two edges after the pop pulse was raised
               if (fifo.fifo_rd) nxt_pend <= 1'b1;
               if (nxt_pend) begin
                  nxt       <= fifo.fifo_data;
                  nxt_valid <= 1'b1;
               end
               if (!tick) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (bit_cnt != BIT_LAST) begin
                     sreg      <= sreg << 1;
                     audio_out <= sreg[DATA_WIDTH-2];
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_PRE && enable && !fifo.fifo_empty)
                        fifo.fifo_rd <= 1'b1;
                  end else if (nxt_valid) begin
                     sreg      <= nxt;
                     audio_out <= nxt[DATA_WIDTH-1];
                     bit_cnt   <= '0;
                     nxt_valid <= 1'b0;
                  end else begin
                     state     <= IDLE;
                     audio_out <= 1'b0;
                     busy      <= 1'b0;
                     audio_sd  <= 1'b0;
                     underrun  <= enable;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_audio_fifo_player.sv
// tb/tb_audio_fifo_player.sv - randomized self-checking bench for audio_fifo_player
// Two instances: CLK_DIV=4 for most scenarios, default CLK_DIV for the long-bit case.
module tb_audio_fifo_player;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int DL = 171;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset  = 1'b1;
   logic enable = 1'b0;
   logic audio_out, audio_sd, busy, underrun;
   logic audio_out_l, audio_sd_l, busy_l, underrun_l;

   audio_fifo_player_if #(.DATA_WIDTH(W)) fa ();
   audio_fifo_player_if #(.DATA_WIDTH(W)) fb ();

   audio_fifo_player #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo(fa.master),
      .audio_out(audio_out), .audio_sd(audio_sd), .busy(busy), .underrun(underrun));

   audio_fifo_player #(.DATA_WIDTH(W)) dut_l (
      .clk(clk), .reset(reset), .enable(enable), .fifo(fb.master),
      .audio_out(audio_out_l), .audio_sd(audio_sd_l), .busy(busy_l), .underrun(underrun_l));

   // FIFO models with one cycle of read latency
   logic [W-1:0] mem_a [0:63];
   logic [W-1:0] mem_b [0:7];
   int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
   logic flush_a = 1'b0;
   assign fa.fifo_empty = (wp_a == rp_a);
   assign fb.fifo_empty = (wp_b == rp_b);

   always @(posedge clk) begin
      if (flush_a) rp_a <= wp_a;
      else if (fa.fifo_rd) begin
         fa.fifo_data <= mem_a[rp_a % 64];
         rp_a <= rp_a + 1;
      end
      if (fb.fifo_rd) begin
         fb.fifo_data <= mem_b[rp_b % 8];
         rp_b <= rp_b + 1;
      end
   end

   int viol = 0;
   logic rd_prev_a = 1'b0, rd_prev_b = 1'b0;
   always @(posedge clk) begin
      if (!reset) begin
         if (fa.fifo_rd && (fa.fifo_empty || rd_prev_a)) viol++;
         if (fb.fifo_rd && (fb.fifo_empty || rd_prev_b)) viol++;
      end
      rd_prev_a <= fa.fifo_rd;
      rd_prev_b <= fb.fifo_rd;
   end

   int pass_cnt = 0;
   int total = 0;
   logic [W-1:0] words [$];

   task automatic load_a(input logic [W-1:0] v);
      mem_a[wp_a % 64] = v;
      wp_a++;
      words.push_back(v);
   endtask

   task automatic flush_fifo_a();
      flush_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush_a = 1'b0;
      words.delete();
   endtask

   // Expected audio k sample points after the start edge: bit b of the stream lives at 2+b*D..
   function automatic logic exp_aud(input int k, input int nw);
      int b;
      if (k < 2 || k >= 2 + nw * W * D) return 1'b0;
      b = (k - 2) / D;
      return words[b / W][W - 1 - (b % W)];
   endfunction

   function automatic logic exp_rd(input int k, input int nw);
      if (k == 0) return 1'b1;
      for (int i = 1; i < nw; i++)
         if (k == 2 + (i - 1) * W * D + (W - 1) * D) return 1'b1;
      return 1'b0;
   endfunction

   task automatic play_score(input int nw, output int e_aud, output int e_busy,
                             output int e_und, output int e_rd);
      int tot;
      tot = 2 + nw * W * D;
      e_aud = 0; e_busy = 0; e_und = 0; e_rd = 0;
      enable = 1'b1;
      for (int k = 0; k < tot + 4; k++) begin
         @(negedge clk);
         if (audio_out !== exp_aud(k, nw)) e_aud++;
         if (busy !== (k < tot) || audio_sd !== (k < tot)) e_busy++;
         if (underrun !== (k == tot)) e_und++;
         if (fa.fifo_rd !== exp_rd(k, nw)) e_rd++;
      end
      enable = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (audio_out !== 1'b0) $display("FAIL reset_audio: got %b want 0", audio_out); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total++; if (audio_sd !== 1'b0) $display("FAIL reset_sd: got %b want 0", audio_sd); else pass_cnt++;
      total++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else pass_cnt++;
      total++; if (fa.fifo_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", fa.fifo_rd); else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_empty_idle();
      int n_rd, n_und, n_aud, n_busy;
      n_rd = 0; n_und = 0; n_aud = 0; n_busy = 0;
      enable = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (fa.fifo_rd !== 1'b0) n_rd++;
         if (underrun !== 1'b0) n_und++;
         if (audio_out !== 1'b0) n_aud++;
         if (busy !== 1'b0) n_busy++;
      end
      enable = 1'b0;
      total++; if (n_rd != 0) $display("FAIL empty_rd: %0d cycles with pop, want 0", n_rd); else pass_cnt++;
      total++; if (n_und != 0) $display("FAIL empty_underrun: %0d pulses, want 0", n_und); else pass_cnt++;
      total++; if (n_aud != 0) $display("FAIL empty_audio: %0d high cycles, want 0", n_aud); else pass_cnt++;
      total++; if (n_busy != 0) $display("FAIL empty_busy: %0d busy cycles, want 0", n_busy); else pass_cnt++;
   endtask

   task automatic test_single_word();
      int ea, eb, eu, er;
      flush_fifo_a();
      load_a(8'hA5);
      play_score(1, ea, eb, eu, er);
      total++; if (ea != 0) $display("FAIL single_audio: %0d bad cycles, want 0", ea); else pass_cnt++;
      total++; if (eb != 0) $display("FAIL single_busy: %0d bad cycles, want 0", eb); else pass_cnt++;
      total++; if (eu != 0) $display("FAIL single_underrun: %0d bad cycles, want 0", eu); else pass_cnt++;
      total++; if (er != 0) $display("FAIL single_rd: %0d bad cycles, want 0", er); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int ea, eb, eu, er;
      flush_fifo_a();
      load_a(8'hF0);
      load_a(8'h0F);
      play_score(2, ea, eb, eu, er);
      total++; if (ea != 0) $display("FAIL b2b_audio: %0d bad cycles, want 0", ea); else pass_cnt++;
      total++; if (eb != 0) $display("FAIL b2b_busy: %0d bad cycles, want 0", eb); else pass_cnt++;
      total++; if (eu != 0) $display("FAIL b2b_underrun: %0d bad cycles, want 0", eu); else pass_cnt++;
      total++; if (er != 0) $display("FAIL b2b_rd: %0d bad cycles, want 0", er); else pass_cnt++;
   endtask

   task automatic test_random_stream(input int iter);
      int ea, eb, eu, er, nw;
      flush_fifo_a();
      nw = $urandom_range(1, 5);
      for (int i = 0; i < nw; i++) load_a(W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      play_score(nw, ea, eb, eu, er);
      total++; if (ea + eb + eu + er != 0)
         $display("FAIL random_%0d: words=%0d bad audio=%0d busy=%0d underrun=%0d rd=%0d, want all 0",
                  iter, nw, ea, eb, eu, er);
      else pass_cnt++;
      total++; if (wp_a - rp_a != 0) $display("FAIL random_%0d_level: got %0d want 0", iter, wp_a - rp_a); else pass_cnt++;
   endtask

   task automatic test_enable_drop();
      int ea, eb, eu, er;
      ea = 0; eb = 0; eu = 0; er = 0;
      flush_fifo_a();
      load_a(8'hFF);
      load_a(8'hFF);
      enable = 1'b1;
      for (int k = 0; k < 46; k++) begin
         @(negedge clk);
         if (audio_out !== (k >= 2 && k < 34)) ea++;
         if (busy !== (k < 34)) eb++;
         if (underrun !== 1'b0) eu++;
         if (fa.fifo_rd !== (k == 0)) er++;
         if (k == 15) enable = 1'b0;
      end
      total++; if (ea != 0) $display("FAIL drop_audio: %0d bad cycles, want 0", ea); else pass_cnt++;
      total++; if (eb != 0) $display("FAIL drop_busy: %0d bad cycles, want 0", eb); else pass_cnt++;
      total++; if (eu != 0) $display("FAIL drop_underrun: %0d pulses, want 0", eu); else pass_cnt++;
      total++; if (er != 0) $display("FAIL drop_rd: %0d bad cycles, want 0", er); else pass_cnt++;
      total++; if (wp_a - rp_a != 1) $display("FAIL drop_level: got %0d want 1", wp_a - rp_a); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int ea, eb, eu, er;
      flush_fifo_a();
      load_a(8'hA5);
      load_a(8'h3C);
      enable = 1'b1;
      for (int k = 0; k < 12; k++) @(negedge clk);
      total++; if (audio_out !== 1'b1) $display("FAIL rstmid_pre_audio: got %b want 1", audio_out); else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      total++; if (audio_out !== 1'b0) $display("FAIL rstmid_audio: got %b want 0", audio_out); else pass_cnt++;
      total++; if (busy !== 1'b0 || audio_sd !== 1'b0)
         $display("FAIL rstmid_busy: got busy=%b sd=%b want 0", busy, audio_sd); else pass_cnt++;
      total++; if (fa.fifo_rd !== 1'b0) $display("FAIL rstmid_rd: got %b want 0", fa.fifo_rd); else pass_cnt++;
      reset = 1'b0;
      void'(words.pop_front());
      play_score(1, ea, eb, eu, er);
      total++; if (ea + eb + eu + er != 0)
         $display("FAIL rstmid_restart: bad audio=%0d busy=%0d underrun=%0d rd=%0d, want all 0", ea, eb, eu, er);
      else pass_cnt++;
   endtask

   task automatic test_default_div();
      int high, ea, eb, eu, tot;
      high = 0; ea = 0; eb = 0; eu = 0;
      tot = 2 + W * DL;
      flush_fifo_a();
      mem_b[wp_b % 8] = 8'h80;
      wp_b++;
      enable = 1'b1;
      for (int k = 0; k < tot + 4; k++) begin
         @(negedge clk);
         if (audio_out_l === 1'b1) high++;
         if (audio_out_l !== (k >= 2 && k < 2 + DL)) ea++;
         if (busy_l !== (k < tot) || audio_sd_l !== (k < tot)) eb++;
         if (underrun_l !== (k == tot)) eu++;
      end
      enable = 1'b0;
      total++; if (high != DL) $display("FAIL div171_high: got %0d clk want %0d", high, DL); else pass_cnt++;
      total++; if (ea != 0) $display("FAIL div171_audio: %0d bad cycles, want 0", ea); else pass_cnt++;
      total++; if (eb != 0) $display("FAIL div171_busy: %0d bad cycles, want 0", eb); else pass_cnt++;
      total++; if (eu != 0) $display("FAIL div171_underrun: %0d bad cycles, want 0", eu); else pass_cnt++;
   endtask

   task automatic test_protocol();
      total++; if (viol != 0) $display("FAIL pop_protocol: %0d violations, want 0", viol); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_empty_idle();
      test_single_word();
      test_back_to_back();
      for (int i = 0; i < 4; i++) test_random_stream(i);
      test_enable_drop();
      test_reset_mid();
      test_default_div();
      test_protocol();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
